// File: rtl/adc_rx_pkg.sv
// Shared types and defaults for the ADC conversion sequencer.
// The free-run trigger timer is optional, enabled by ADC_CNV_FREERUN_EN.
package adc_rx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CNV    = 3'd1,
      ST_CONV   = 3'd2,
      ST_BURST  = 3'd3,
      ST_SETTLE = 3'd4,
      ST_LATCH  = 3'd5
   } state_e;

   localparam int unsigned DEF_CNV_HIGH_CYC   = 2;
   localparam int unsigned DEF_CONV_CYC       = 6;
   localparam int unsigned DEF_LATCH_DLY_CYC  = 3;
   localparam int unsigned DEF_LATCH_HIGH_CYC = 2;
   localparam int unsigned DEF_PERIOD_W       = 16;

   // Shared phase counter width; every timing parameter must fit below 2**CNT_W.
   localparam int unsigned CNT_W = 8;

   // Clock-enable cycles per frame: two bits per lane per DDR clock.
   function automatic logic [3:0] burst_len(input logic bits_18, input logic two_lane);
      logic [3:0] n;
      case ({bits_18, two_lane})
         2'b10:   n = 4'd9;
         2'b00:   n = 4'd8;
         2'b11:   n = 4'd5;
         default: n = 4'd4;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/adc_cnv_period_timer.sv
// Free-run trigger generator: one tick every `period` cycles while free_run is high.
// Only instantiated when ADC_CNV_FREERUN_EN is defined.
module adc_cnv_period_timer
   import adc_rx_pkg::*;
#(
   parameter int unsigned PERIOD_W = DEF_PERIOD_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                free_run,
   input  logic [PERIOD_W-1:0] period,
   output logic                tick
);

   logic                free_run_q;
   logic [PERIOD_W-1:0] period_q;
   logic [PERIOD_W-1:0] cnt_d, cnt_q;
   logic                restart;
   logic                enabled;

   always_ff @(posedge clk) begin
      if (rst) begin
         free_run_q <= 1'b0;
         period_q   <= '0;
         cnt_q      <= '0;
      end else begin
         free_run_q <= free_run;
         period_q   <= period;
         cnt_q      <= cnt_d;
      end
   end

   // Any change of mode or period restarts the phase from the current cycle.
   always_comb begin
      restart = (free_run != free_run_q) || (period != period_q);
      enabled = free_run_q && (period_q != '0);
      tick    = enabled && !restart && (cnt_q == '0);
      cnt_d   = cnt_q;
      if (restart) begin
         cnt_d = period - PERIOD_W'(1);
      end else if (tick) begin
         cnt_d = period_q - PERIOD_W'(1);
      end else if (enabled) begin
         cnt_d = cnt_q - PERIOD_W'(1);
      end
   end

endmodule

// File: rtl/adc_cnv_ctrl.sv
// Conversion sequencer for the LTC2385/6/7 deserializer: CNV, wait, clock burst, LATCH.
// Define ADC_CNV_FREERUN_EN to compile in the internal free-run trigger timer.
//
// state     | meaning
// ST_IDLE   | waiting for start or free-run tick
// ST_CNV    | cnv held high
// ST_CONV   | converter busy, no clocks
// ST_BURST  | clk_gate_en high for N cycles
// ST_SETTLE | waiting out DCO/data round trip
// ST_LATCH  | latch held high
module adc_cnv_ctrl
   import adc_rx_pkg::*;
#(
   parameter int unsigned CNV_HIGH_CYC   = DEF_CNV_HIGH_CYC,
   parameter int unsigned CONV_CYC       = DEF_CONV_CYC,
   parameter int unsigned LATCH_DLY_CYC  = DEF_LATCH_DLY_CYC,
   parameter int unsigned LATCH_HIGH_CYC = DEF_LATCH_HIGH_CYC,
   parameter int unsigned PERIOD_W       = DEF_PERIOD_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                bits_18,
   input  logic                two_lane,
   input  logic                start,
   input  logic                free_run,
   input  logic [PERIOD_W-1:0] period,
   output logic                cnv,
   output logic                clk_gate_en,
   output logic                latch,
   output logic                busy,
   output logic                done,
   output logic                overrun
);

   localparam logic [CNT_W-1:0] CNV_RLD   = CNT_W'(CNV_HIGH_CYC - 1);
   localparam logic [CNT_W-1:0] CONV_RLD  = CNT_W'(CONV_CYC - 1);
   localparam logic [CNT_W-1:0] SETL_RLD  = CNT_W'(LATCH_DLY_CYC - 1);
   localparam logic [CNT_W-1:0] LATCH_RLD = CNT_W'(LATCH_HIGH_CYC - 1);

   state_e           state_d, state_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;
   logic             bits_18_d, bits_18_q;
   logic             two_lane_d, two_lane_q;
   logic             cnv_d, cnv_q;
   logic             clk_gate_en_d, clk_gate_en_q;
   logic             latch_d, latch_q;
   logic             busy_d, busy_q;
   logic             done_d, done_q;
   logic             overrun_d, overrun_q;
   logic             tick;
   logic             trig;
   logic             cnt_zero;

`ifdef ADC_CNV_FREERUN_EN
   adc_cnv_period_timer #(
      .PERIOD_W (PERIOD_W)
   ) u_period_timer (
      .clk      (clk),
      .rst      (rst),
      .free_run (free_run),
      .period   (period),
      .tick     (tick)
   );
`else
   logic unused_freerun;
   assign unused_freerun = ^{free_run, period};
   assign tick           = 1'b0;
`endif

   assign trig     = start | tick;
   assign cnt_zero = (cnt_q == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         bits_18_q     <= 1'b0;
         two_lane_q    <= 1'b0;
         cnv_q         <= 1'b0;
         clk_gate_en_q <= 1'b0;
         latch_q       <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         bits_18_q     <= bits_18_d;
         two_lane_q    <= two_lane_d;
         cnv_q         <= cnv_d;
         clk_gate_en_q <= clk_gate_en_d;
         latch_q       <= latch_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         overrun_q     <= overrun_d;
      end
   end

   // Counter is reloaded with (duration - 1) on every state entry.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bits_18_d  = bits_18_q;
      two_lane_d = two_lane_q;
      case (state_q)
         ST_IDLE: begin
            if (trig) begin
               state_d    = ST_CNV;
               cnt_d      = CNV_RLD;
               bits_18_d  = bits_18;
               two_lane_d = two_lane;
            end
         end
         ST_CNV: begin
            if (cnt_zero) begin
               state_d = ST_CONV;
               cnt_d   = CONV_RLD;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_CONV: begin
            if (cnt_zero) begin
               state_d = ST_BURST;
               cnt_d   = CNT_W'(burst_len(bits_18_q, two_lane_q)) - CNT_W'(1);
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_BURST: begin
            if (cnt_zero) begin
               state_d = ST_SETTLE;
               cnt_d   = SETL_RLD;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_SETTLE: begin
            if (cnt_zero) begin
               state_d = ST_LATCH;
               cnt_d   = LATCH_RLD;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_LATCH: begin
            if (cnt_zero) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs decoded from the next state so the registered copies line up with state_q.
   always_comb begin
      cnv_d         = (state_d == ST_CNV);
      clk_gate_en_d = (state_d == ST_BURST);
      latch_d       = (state_d == ST_LATCH);
      busy_d        = (state_d != ST_IDLE);
      done_d        = (state_q == ST_LATCH) && (state_d == ST_IDLE);
      overrun_d     = trig && (state_q != ST_IDLE);
   end

   assign cnv         = cnv_q;
   assign clk_gate_en = clk_gate_en_q;
   assign latch       = latch_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_adc_cnv_ctrl.sv
// Scoreboard bench for adc_cnv_ctrl; free-run scenarios run only when ADC_CNV_FREERUN_EN is defined.
module tb_adc_cnv_ctrl;

   localparam int CH   = 2;
   localparam int CONV = 6;
   localparam int LD   = 3;
   localparam int LH   = 2;

   localparam int I_CNV  = 0;
   localparam int I_GATE = 1;
   localparam int I_LAT  = 2;
   localparam int I_BUSY = 3;
   localparam int I_DONE = 4;
   localparam int I_OVR  = 5;

   typedef struct {
      int rise;
      int len;
   } pulse_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        bits_18 = 1'b0;
   logic        two_lane = 1'b0;
   logic        start = 1'b0;
   logic        free_run = 1'b0;
   logic [15:0] period = 16'd0;
   logic        cnv, clk_gate_en, latch, busy, done, overrun;

   int     cyc = 0;
   int     checks = 0;
   int     errors = 0;
   pulse_t exp_q[6][$];
   int     rise_at[6];
   logic [5:0] prev_v = 6'b0;
   string  names[6] = '{"cnv", "clk_gate_en", "latch", "busy", "done", "overrun"};

   adc_cnv_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .bits_18     (bits_18),
      .two_lane    (two_lane),
      .start       (start),
      .free_run    (free_run),
      .period      (period),
      .cnv         (cnv),
      .clk_gate_en (clk_gate_en),
      .latch       (latch),
      .busy        (busy),
      .done        (done),
      .overrun     (overrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic push(input int idx, input int rise, input int len);
      pulse_t p;
      p.rise = rise;
      p.len  = len;
      exp_q[idx].push_back(p);
   endtask

   task automatic push_frame(input int s, input int n);
      int l;
      l = CH + CONV + n + LD + LH;
      push(I_CNV,  s + 1, CH);
      push(I_GATE, s + 1 + CH + CONV, n);
      push(I_LAT,  s + 1 + CH + CONV + n + LD, LH);
      push(I_BUSY, s + 1, l);
      push(I_DONE, s + l + 1, 1);
   endtask

   task automatic at_cycle(input int c);
      if (cyc > c) begin
         $display("FAIL schedule: at cycle %0d, wanted %0d", cyc, c);
         $fatal(1, "schedule overrun");
      end
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_start(input int c);
      at_cycle(c);
      start = 1'b1;
      at_cycle(c + 1);
      start = 1'b0;
   endtask

   // Monitor: every completed pulse on an output is matched against its queue.
   always @(negedge clk) begin
      logic [5:0] v;
      pulse_t     e;
      v = {overrun, done, busy, latch, clk_gate_en, cnv};
      for (int i = 0; i < 6; i++) begin
         if (v[i] === 1'b1 && prev_v[i] !== 1'b1) rise_at[i] = cyc;
         if (v[i] !== 1'b1 && prev_v[i] === 1'b1) begin
            if (exp_q[i].size() == 0) begin
               checks++;
               errors++;
               $display("FAIL %s unexpected pulse: rise %0d len %0d, expected none",
                        names[i], rise_at[i], cyc - rise_at[i]);
            end else begin
               e = exp_q[i].pop_front();
               chk({names[i], " rise"}, rise_at[i], e.rise);
               chk({names[i], " len"}, cyc - rise_at[i], e.len);
            end
         end
      end
      prev_v = v;
   end

   initial begin
      at_cycle(2);
      @(negedge clk);
      chk("reset outputs", int'({cnv, clk_gate_en, latch, busy, done, overrun}), 0);
      at_cycle(3);
      rst = 1'b0;

      // 18-bit one lane, with a dropped mid-frame start
      at_cycle(5);
      bits_18  = 1'b1;
      two_lane = 1'b0;
      push(I_CNV, 11, 2);
      push(I_GATE, 19, 9);
      push(I_LAT, 31, 2);
      push(I_BUSY, 11, 22);
      push(I_DONE, 33, 1);
      push(I_OVR, 16, 1);
      pulse_start(10);
      pulse_start(15);

      // 16-bit two lane: N = 4, L = 17
      at_cycle(35);
      bits_18  = 1'b0;
      two_lane = 1'b1;
      push_frame(40, 4);
      pulse_start(40);

      // bits_18 dropped mid-burst, then a back-to-back frame in the done cycle
      at_cycle(65);
      bits_18  = 1'b1;
      two_lane = 1'b0;
      push_frame(70, 9);
      pulse_start(70);
      at_cycle(81);
      bits_18 = 1'b0;
      push_frame(93, 8);
      pulse_start(93);

      // 18-bit two lane, config changed while previous frame still busy
      at_cycle(100);
      bits_18  = 1'b1;
      two_lane = 1'b1;
      push_frame(120, 5);
      pulse_start(120);

      // reset during burst truncates the frame
      at_cycle(145);
      bits_18  = 1'b1;
      two_lane = 1'b0;
      push(I_CNV, 151, 2);
      push(I_GATE, 159, 3);
      push(I_BUSY, 151, 11);
      pulse_start(150);
      at_cycle(161);
      rst = 1'b1;
      at_cycle(162);
      rst      = 1'b0;
      bits_18  = 1'b0;
      @(negedge clk);
      chk("mid-frame reset outputs", int'({cnv, clk_gate_en, latch, busy, done, overrun}), 0);
      push_frame(164, 8);
      pulse_start(164);

      at_cycle(195);
      bits_18  = 1'b1;
      two_lane = 1'b0;
`ifdef ADC_CNV_FREERUN_EN
      // period 25 > L: ticks at 225, 250, 275, no overrun
      push_frame(225, 9);
      push_frame(250, 9);
      push_frame(275, 9);
      at_cycle(200);
      period   = 16'd25;
      free_run = 1'b1;
      at_cycle(290);
      free_run = 1'b0;
      at_cycle(300);
      period = 16'd10;
      // period 10 < L: ticks every 10 from 320; only idle-time ticks accepted
      push_frame(320, 9);
      push(I_OVR, 331, 1);
      push(I_OVR, 341, 1);
      push_frame(350, 9);
      push(I_OVR, 361, 1);
      push(I_OVR, 371, 1);
      push_frame(380, 9);
      at_cycle(310);
      free_run = 1'b1;
      pulse_start(380);
      at_cycle(385);
      free_run = 1'b0;
`else
      // timer absent: free_run and period must not trigger anything
      at_cycle(200);
      period   = 16'd5;
      free_run = 1'b1;
      at_cycle(290);
      free_run = 1'b0;
`endif

      at_cycle(420);
      for (int i = 0; i < 6; i++) begin
         chk({names[i], " pending expected pulses"}, exp_q[i].size(), 0);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/adc_cnv_ctrl.md
# adc_cnv_ctrl

Conversion sequencer sitting directly upstream of the LTC2385/2386/2387 deserializer. On each trigger (external or internal free-run timer) it:
- pulses CNV to the converter;
- waits out the conversion;
- emits a clock-enable burst of exactly the right length for the selected bit width and lane count;
- after a round-trip settle delay, pulses LATCH so the deserializer loads its parallel output.

## Interface
- CNV_HIGH_CYC, default 2: cycles CNV is held high (≥1).
- CONV_CYC, default 6: cycles between CNV falling and first burst cycle (≥1).
- LATCH_DLY_CYC, default 3: cycles between burst end and LATCH rising; covers DCO/data round trip (≥1).
- LATCH_HIGH_CYC, default 2: LATCH high width (≥1).
- PERIOD_W, default 16: width of free-run period.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- bits_18  in  1  1 = 18-bit frame, 0 = 16-bit.
- two_lane  in  1  1 = lanes A and B, 0 = lane A only.
- start  in  1  single-cycle trigger.
- free_run  in  1  enables internal periodic trigger.
- period  in  PERIOD_W  free-run trigger period in clk cycles.
- cnv  out  1  conversion start to ADC.
- clk_gate_en  out  1  enable for the gated ADC clock (DDR output cell).
- latch  out  1  LATCH to deserializer.
- busy  out  1  high in every non-IDLE state.
- done  out  1  one-cycle pulse on return to IDLE.
- overrun  out  1  one-cycle pulse when a trigger is dropped.

## Operation
- FSM states and transitions:
  - IDLE → CNV on trigger.
  - CNV (CNV_HIGH_CYC) → CONV (CONV_CYC) → BURST (N) → SETTLE (LATCH_DLY_CYC) → LATCH (LATCH_HIGH_CYC) → IDLE.
- Burst count N = ceil(bits/2) for one lane, ceil(bits/4) for two lanes:
  - 18/one lane = 9
  - 16/one lane = 8
  - 18/two lane = 5
  - 16/two lane = 4
- bits_18 and two_lane are captured at trigger. Changes mid-frame have no effect until the next frame.
- Trigger = start OR free-run tick.
  - Accepted only in IDLE.
  - A trigger arriving in any other state is dropped and pulses overrun.
  - Simultaneous start and tick in IDLE counts as one accepted trigger, with no overrun.
- Frame length L = CNV_HIGH_CYC + CONV_CYC + N + LATCH_DLY_CYC + LATCH_HIGH_CYC.
- Single shared down-counter, reloaded on every state entry, 5 bits minimum.
- Reset (including mid-frame): state IDLE; counters cleared; captured config = 16-bit/one lane; all outputs 0. No partial burst or latch completes.

## Timing
- All outputs are registered and decoded from the state.
- start high at edge k → cnv = 1 for cycles k+1 … k+CNV_HIGH_CYC.
- clk_gate_en is high for exactly N consecutive cycles, starting CONV_CYC cycles after cnv falls.
- latch rises LATCH_DLY_CYC cycles after clk_gate_en falls.
- done pulses in the first IDLE cycle. A start in that same cycle is accepted, so back-to-back frames have period L+1.
- busy = 1 from cycle k+1 through the last LATCH cycle.

## Configuration
- Macro ADC_CNV_FREERUN_EN.
  - Defined: the internal period timer is compiled in. When free_run = 1 and period ≠ 0, it emits a tick every `period` cycles, counted from when free_run rises. period = 0 means no ticks.
  - Not defined: the timer is absent, free_run and period are ignored, and start is the only trigger.
- Port list is identical in both builds.

## Structure
- Shared package adc_rx_pkg:
  - FSM state enum;
  - default timing constants;
  - function returning N from (bits_18, two_lane).
- One sub-module, adc_cnv_period_timer: the free-run tick generator, instantiated only under ADC_CNV_FREERUN_EN. It resets with rst and restarts its count whenever free_run or period changes.

## Test plan
- Defaults, bits_18 = 1, two_lane = 0, start at cycle 10 → cnv high cycles 11–12; clk_gate_en high 19–27 (9 cycles); latch high 31–32; done at 33.
- bits_18 = 0, two_lane = 1, start → exactly 4 clk_gate_en cycles; L = 17; done 18 cycles after start.
- start asserted again at cycle 15 (mid-frame) → overrun pulse at cycle 16; frame timing unchanged; no second cnv.
- Toggle bits_18 1→0 during BURST → current burst still 9 cycles; next frame 8.
- rst asserted during BURST → next cycle all outputs 0, state IDLE; a start 2 cycles later yields a full normal frame.
- With ADC_CNV_FREERUN_EN, free_run = 1:
  - period = 25 → cnv rising edges exactly 25 cycles apart, no overrun;
  - period = 10 (< L) → overrun pulses and cnv spacing stays ≥ L+1.
